modular_multiplier_ds: RTL and testbench
========================================

# modular_multiplier_ds

Digit-serial modular multiplier computing `result = (A * B) mod p` (or `A*A mod p`) with an explicit start/done handshake. It is the parametrised successor of the bit-serial multiplier and sits beneath the ECC point-add/point-double datapath. Each cycle it processes `D` multiplier bits MSB-first with interleaved reduction. Only comparisons and subtractions are used, with no `%` operator. Operand range errors are flagged instead of producing silent garbage.

## Interface
- `N`, 231: operand/modulus width in bits.
- `D`, 1: multiplier bits consumed per cycle; 1 ≤ D ≤ N.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted when `ready`=1.
- `mode`  in  1  0 = multiply A*B, 1 = square A*A (B ignored).
- `A`, `B`, `p`  in  N each  operands and modulus; sampled only on the accept cycle.
- `ready`  out  1  high in IDLE and DONE.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  valid with `done`; 1 = range error.
- `result`  out  N  product; valid from `done`, held until the next accept.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**: on `start`, latch the following:
  - `a_reg`=A, `b_reg`=(mode ? A : B), `p_reg`=p, `R`=0;
  - `cnt`=ITER−1, where ITER = ceil(N/D).
- **Range check on accept:**
  - Error conditions: `p` < 2, A ≥ p, or (mode=0 and B ≥ p).
  - On error, go straight to DONE with `err`=1 and `result`=0.
  - Otherwise go to RUN.
- **RUN**:
  - Each cycle applies D steps, taking multiplier bits from `a_reg` MSB-first.
  - Bit positions start at ITER·D−1. Positions ≥ N read as 0 (leading-zero padding).
  - One step is:
    - `t = 2R`; if `t ≥ p`, `t −= p`;
    - if bit=1, `t += b_reg`; if `t ≥ p`, `t −= p`;
    - `R = t`.
  - Intermediates are N+1 bits wide. The invariant R < p holds after every step.
  - Decrement `cnt`. When `cnt`=0, go to DONE and load `result`=R, `err`=0.
- **DONE**:
  - `done`=1 for exactly one cycle.
  - Next state is IDLE, or RUN/DONE if `start` is asserted in this cycle (back-to-back accept allowed).
- `start` during RUN is ignored: no queueing and no effect on the current operation.
- Operand inputs may change freely after the accept cycle.

## Timing
- **Reset values:** asynchronous on `reset_n`=0, taking effect immediately.
  - State = IDLE; `ready`=1; `busy`=0; `done`=0; `err`=0; `result`=0.
  - Internal registers are all cleared to 0.
- **Reset mid-RUN:** aborts the operation. No `done` is produced. `ready` is 1 on the first edge after release.
- **Latency:** start accepted at edge t → RUN during t+1 … t+ITER → `done` high in cycle t+ITER+1.
  - Example: N=8, D=1 → done at t+9.
  - Example: N=8, D=3 → ITER=3 → done at t+4.
- **Error latency:** `done`=1 with `err`=1 in cycle t+1.
- **Throughput:** one operation per ITER+1 cycles, because of the back-to-back accept in DONE.
- **`result` hold:** `result` changes only at the RUN→DONE transition, the error-DONE transition, or reset.

## Structure
- **Package `modmul_pkg`:**
  - state enum (IDLE, RUN, DONE);
  - function `iter_count(N, D)` = ceil(N/D);
  - mode constants MODE_MUL=0, MODE_SQR=1.
- **Sub-module `modmul_step`:**
  - Combinational single interleaved step: inputs R, bit, b, p; output R'; parameter N.
  - Instantiated D times in a generate chain inside the top.
- The FSM, counter, operand registers and range check live in the top.

## Test plan
- **Basic multiply:** N=8, D=1, p=251, A=200, B=123, mode=0 → `done` at t+9, `result`=2, `err`=0.
- **Square and digit width:** N=8, D=3, mode=1, A=17, p=251 (B=0xFF, ignored) → `done` at t+4, `result`=38.
- **Edge operands:**
  - A=0, B=250, p=251 → 0.
  - A=B=250, p=251 → 1.
  - p=2, A=1, B=1 → 1.
- **Range errors:**
  - A=251, p=251 → `done`+`err` at t+1, `result`=0.
  - p=1 → `err`.
  - mode=1 with B=255 ≥ p → no error.
- **Handshake:**
  - `start` pulsed mid-RUN with new operands → ignored; the original result is returned.
  - `start` during DONE → next op accepted; second `done` ITER+1 cycles later.
  - `reset_n` low mid-RUN → outputs cleared at once, no `done`, `ready`=1 after release.
- **Random regression:** N=231, D ∈ {1, 4, 7}, 10k random A, B < p with random p ≥ 2 → matches the reference (A*B) mod p; latency exactly ITER+1.

Source files
------------

// File: rtl/modular_multiplier_ds_pkg.sv
// Shared types and helpers for the digit-serial modular multiplier.
package modmul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_SQR = 1'b1;

   function automatic int iter_count(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/modular_multiplier_ds_if.sv
// Start/done request bus between a requester and the modular multiplier.
interface modular_multiplier_ds_if #(
   parameter int N = 231
);
   logic         start;
   logic         mode;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [N-1:0] p;
   logic         ready;
   logic         busy;
   logic         done;
   logic         err;
   logic [N-1:0] result;

   modport master (
      output start, mode, A, B, p,
      input  ready, busy, done, err, result
   );

   modport slave (
      input  start, mode, A, B, p,
      output ready, busy, done, err, result
   );
endinterface

// File: rtl/modular_multiplier_ds_step.sv
// One interleaved double-and-add step: R' = (2R + bit*b) mod p, given R, b < p.
module modmul_step #(
   parameter int N = 231
) (
   input  logic [N-1:0] r_i,
   input  logic         bit_i,
   input  logic [N-1:0] b_i,
   input  logic [N-1:0] p_i,
   output logic [N-1:0] r_o
);
   logic [N:0] pe;
   logic [N:0] t0;
   logic [N:0] t1;
   logic [N:0] t2;

   assign pe = {1'b0, p_i};
   assign t0 = {r_i, 1'b0};
   assign t1 = (t0 >= pe) ? t0 - pe : t0;
   // t1 < p, so t1 + b < 2p always fits in N+1 bits
   assign t2 = bit_i ? t1 + {1'b0, b_i} : t1;
   assign r_o = (t2 >= pe) ? N'(t2 - pe) : t2[N-1:0];
endmodule

// File: rtl/modular_multiplier_ds.sv
// Digit-serial (A*B) mod p, D multiplier bits per cycle, MSB-first.
module modular_multiplier_ds
   import modmul_pkg::*;
#(
   parameter int N = 231,
   parameter int D = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   modular_multiplier_ds_if.slave bus
);
   localparam int ITER = iter_count(N, D);
   localparam int W    = ITER * D;
   localparam int CW   = $clog2(ITER + 1);

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [N-1:0]    p_q, p_d;
   logic [N-1:0]    r_q, r_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    res_q, res_d;
   logic            err_q, err_d;
   logic            range_err;
   logic [D:0][N-1:0] chain;

   assign chain[0] = r_q;

   // a_q is zero-extended to ITER*D bits so the padded leading positions read 0
   for (genvar g = 0; g < D; g++) begin : g_step
      modmul_step #(.N(N)) u_step (
         .r_i   (chain[g]),
         .bit_i (a_q[W-1-g]),
         .b_i   (b_q),
         .p_i   (p_q),
         .r_o   (chain[g+1])
      );
   end

   assign range_err = (bus.p < N'(2)) || (bus.A >= bus.p) ||
                      ((bus.mode == MODE_MUL) && (bus.B >= bus.p));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.start) begin
               a_d   = W'(bus.A);
               b_d   = (bus.mode == MODE_SQR) ? bus.A : bus.B;
               p_d   = bus.p;
               r_d   = '0;
               cnt_d = CW'(ITER - 1);
               if (range_err) begin
                  state_d = ST_DONE;
                  res_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            r_d   = chain[D];
            a_d   = a_q << D;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               res_d   = chain[D];
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign bus.ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign bus.busy   = (state_q == ST_RUN);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.err    = err_q;
   assign bus.result = res_q;
endmodule

// File: tb/tb_modular_multiplier_ds.sv
// Directed bench for modular_multiplier_ds: N=8 D=1, N=8 D=3, N=231 D=7.
module tb_modular_multiplier_ds;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   modular_multiplier_ds_if #(.N(8))   if1 ();
   modular_multiplier_ds_if #(.N(8))   if3 ();
   modular_multiplier_ds_if #(.N(231)) ifw ();

   modular_multiplier_ds #(.N(8), .D(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(if1));
   modular_multiplier_ds #(.N(8), .D(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .bus(if3));
   modular_multiplier_ds #(.N(231), .D(7)) dutw (
      .clk(clk), .reset_n(reset_n), .bus(ifw));

   task automatic drive(input int sel, input logic [230:0] a, b, p,
                        input logic m, input logic s);
      case (sel)
         1: begin
            if1.A = a[7:0]; if1.B = b[7:0]; if1.p = p[7:0];
            if1.mode = m; if1.start = s;
         end
         3: begin
            if3.A = a[7:0]; if3.B = b[7:0]; if3.p = p[7:0];
            if3.mode = m; if3.start = s;
         end
         default: begin
            ifw.A = a; ifw.B = b; ifw.p = p;
            ifw.mode = m; ifw.start = s;
         end
      endcase
   endtask

   function automatic logic done_of(input int sel);
      case (sel)
         1: return if1.done;
         3: return if3.done;
         default: return ifw.done;
      endcase
   endfunction

   function automatic logic err_of(input int sel);
      case (sel)
         1: return if1.err;
         3: return if3.err;
         default: return ifw.err;
      endcase
   endfunction

   function automatic logic [230:0] res_of(input int sel);
      case (sel)
         1: return 231'(if1.result);
         3: return 231'(if3.result);
         default: return ifw.result;
      endcase
   endfunction

   // lat = edges after the accept edge until done is seen (0 for range errors)
   task automatic wait_done(input int sel, input int lat0,
                            output logic [230:0] res, output logic e,
                            output int lat);
      lat = lat0;
      while (!done_of(sel) && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = res_of(sel);
      e   = err_of(sel);
   endtask

   task automatic op(input int sel, input logic [230:0] a, b, p,
                     input logic m, output logic [230:0] res,
                     output logic e, output int lat);
      drive(sel, a, b, p, m, 1'b1);
      @(posedge clk); #1;
      drive(sel, a, b, p, m, 1'b0);
      wait_done(sel, 0, res, e, lat);
   endtask

   task automatic test_reset;
      checks++;
      if (if1.ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", if1.ready);
      end
      checks++;
      if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got busy=%b done=%b err=%b exp 0 0 0",
                  if1.busy, if1.done, if1.err);
      end
      checks++;
      if (if1.result !== 8'd0 || ifw.result !== 231'd0) begin
         errors++; $display("FAIL reset_result got %0d exp 0", if1.result);
      end
      checks++;
      if (if3.ready !== 1'b1 || ifw.ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready_others got %b%b exp 11",
                            if3.ready, ifw.ready);
      end
   endtask

   task automatic test_basic;
      logic [230:0] r; logic e; int lat;
      op(1, 200, 123, 251, 1'b0, r, e, lat);
      checks++;
      if (r !== 231'd2 || e !== 1'b0) begin
         errors++; $display("FAIL basic_d1 got %0d err=%b exp 2 err=0", r, e);
      end
      checks++;
      if (lat !== 8) begin
         errors++; $display("FAIL basic_d1_lat got %0d exp 8", lat);
      end
      op(3, 200, 123, 251, 1'b0, r, e, lat);
      checks++;
      if (r !== 231'd2 || lat !== 3) begin
         errors++; $display("FAIL basic_d3 got %0d lat %0d exp 2 lat 3", r, lat);
      end
   endtask

   task automatic test_square;
      logic [230:0] r; logic e; int lat;
      op(3, 17, 8'hFF, 251, 1'b1, r, e, lat);
      checks++;
      if (r !== 231'd38 || e !== 1'b0) begin
         errors++; $display("FAIL square_d3 got %0d err=%b exp 38 err=0", r, e);
      end
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL square_d3_lat got %0d exp 3", lat);
      end
   endtask

   task automatic test_edge;
      logic [230:0] r; logic e; int lat;
      op(1, 0, 250, 251, 1'b0, r, e, lat);
      checks++;
      if (r !== 231'd0 || e !== 1'b0) begin
         errors++; $display("FAIL edge_zero got %0d exp 0", r);
      end
      op(1, 250, 250, 251, 1'b0, r, e, lat);
      checks++;
      if (r !== 231'd1 || e !== 1'b0) begin
         errors++; $display("FAIL edge_max got %0d exp 1", r);
      end
      op(3, 1, 1, 2, 1'b0, r, e, lat);
      checks++;
      if (r !== 231'd1 || e !== 1'b0) begin
         errors++; $display("FAIL edge_p2 got %0d exp 1", r);
      end
   endtask

   task automatic test_range;
      logic [230:0] r; logic e; int lat;
      op(1, 251, 3, 251, 1'b0, r, e, lat);
      checks++;
      if (e !== 1'b1 || r !== 231'd0 || lat !== 0) begin
         errors++; $display("FAIL range_a got err=%b res=%0d lat=%0d exp 1 0 0",
                            e, r, lat);
      end
      op(1, 0, 0, 1, 1'b0, r, e, lat);
      checks++;
      if (e !== 1'b1 || lat !== 0) begin
         errors++; $display("FAIL range_p1 got err=%b lat=%0d exp 1 0", e, lat);
      end
      op(3, 5, 251, 251, 1'b0, r, e, lat);
      checks++;
      if (e !== 1'b1 || r !== 231'd0) begin
         errors++; $display("FAIL range_b got err=%b res=%0d exp 1 0", e, r);
      end
      op(1, 17, 255, 251, 1'b1, r, e, lat);
      checks++;
      if (e !== 1'b0 || r !== 231'd38 || lat !== 8) begin
         errors++; $display("FAIL range_sqr_b got err=%b res=%0d lat=%0d exp 0 38 8",
                            e, r, lat);
      end
   endtask

   task automatic test_ignore_start;
      logic [230:0] r; logic e; int lat;
      drive(1, 200, 123, 251, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(1, 200, 123, 251, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      drive(1, 5, 5, 7, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(1, 9, 9, 11, 1'b1, 1'b0);
      wait_done(1, 4, r, e, lat);
      checks++;
      if (r !== 231'd2 || lat !== 8) begin
         errors++; $display("FAIL ignore_start got %0d lat %0d exp 2 lat 8", r, lat);
      end
      @(posedge clk); #1;
      checks++;
      if (if1.done !== 1'b0 || if1.ready !== 1'b1 || if1.result !== 8'd2) begin
         errors++; $display("FAIL done_pulse got done=%b ready=%b res=%0d exp 0 1 2",
                            if1.done, if1.ready, if1.result);
      end
   endtask

   task automatic test_back_to_back;
      logic [230:0] r; logic e; int lat;
      op(3, 17, 0, 251, 1'b1, r, e, lat);
      checks++;
      if (r !== 231'd38) begin
         errors++; $display("FAIL b2b_first got %0d exp 38", r);
      end
      drive(3, 200, 123, 251, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(3, 0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (if3.busy !== 1'b1 || if3.result !== 8'd38) begin
         errors++; $display("FAIL b2b_accept got busy=%b res=%0d exp 1 38",
                            if3.busy, if3.result);
      end
      wait_done(3, 0, r, e, lat);
      checks++;
      if (r !== 231'd2 || lat !== 3) begin
         errors++; $display("FAIL b2b_second got %0d lat %0d exp 2 lat 3", r, lat);
      end
   endtask

   task automatic test_reset_mid;
      int seen = 0;
      drive(1, 250, 250, 251, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      checks++;
      if (if1.busy !== 1'b0 || if1.ready !== 1'b1 || if1.done !== 1'b0 ||
          if1.result !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid got busy=%b ready=%b done=%b res=%0d exp 0 1 0 0",
                  if1.busy, if1.ready, if1.done, if1.result);
      end
      #4;
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (if1.ready !== 1'b1 || if1.busy !== 1'b0) begin
         errors++; $display("FAIL reset_release got ready=%b busy=%b exp 1 0",
                            if1.ready, if1.busy);
      end
      repeat (12) begin
         @(posedge clk); #1;
         if (if1.done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL reset_no_done got %0d done cycles exp 0", seen);
      end
   endtask

   task automatic test_random;
      logic [230:0] a, b, p, r, expv;
      logic [461:0] prod;
      logic [255:0] raw;
      logic e, m;
      int lat;
      int bad = 0;
      for (int i = 0; i < 200; i++) begin
         for (int k = 0; k < 8; k++) raw[k*32 +: 32] = $urandom;
         p = raw[230:0];
         if (i % 17 == 3) p = 231'($urandom_range(2, 300));
         if (p < 231'd2) p = 231'd2;
         for (int k = 0; k < 8; k++) raw[k*32 +: 32] = $urandom;
         a = raw[230:0] % p;
         for (int k = 0; k < 8; k++) raw[k*32 +: 32] = $urandom;
         b = raw[230:0] % p;
         if (i == 0) a = p - 231'd1;
         if (i == 0) b = p - 231'd1;
         m = (i % 5 == 1);
         prod = 462'(a) * (m ? 462'(a) : 462'(b));
         expv = 231'(prod % 462'(p));
         op(7, a, b, p, m, r, e, lat);
         checks++;
         if (r !== expv || e !== 1'b0 || lat !== 33) begin
            errors++; bad++;
            if (bad < 5)
               $display("FAIL random_%0d got %h err=%b lat=%0d exp %h err=0 lat=33",
                        i, r, e, lat, expv);
         end
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 1'b0, 1'b0);
      drive(3, 0, 0, 0, 1'b0, 1'b0);
      drive(7, 0, 0, 0, 1'b0, 1'b0);
      #12;
      test_reset;
      #4;
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_basic;
      test_square;
      test_edge;
      test_range;
      test_ignore_start;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
